// File: rtl/angle_buf_writer_pkg.sv
// Shared types for the angle history buffer and the eps selector that reads it.
package angle_buf_writer_pkg;

    localparam int unsigned ANG_W     = 13;
    localparam int unsigned THETA_W   = 8;
    localparam int unsigned EPS_W     = 16;
    localparam int unsigned BUF_DEPTH = 256;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);

    // 1/(2*pi) in unsigned Q0.16
    localparam logic [15:0] INV_TWO_PI = 16'd10430;

    typedef logic signed [ANG_W-1:0] ang_t;
    typedef logic        [THETA_W-1:0] theta_t;
    typedef logic signed [EPS_W-1:0]   eps_t;
    typedef logic        [PTR_W-1:0]   ptr_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2,
        FROZEN = 2'd3
    } buf_state_t;

endpackage

// File: rtl/angle_buf_writer.sv
// Circular angle history writer: one sample per handshake, newest index published,
// fill tracking, and a freeze mode that holds contents stable for the reader.
module angle_buf_writer
    import angle_buf_writer_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  ang_t                     angle_in,
    input  logic                     freeze,
    input  logic                     flush,
    output ang_t                     angle_buf [0:DEPTH-1],
    output logic [$clog2(DEPTH)-1:0] write_ptr,
    output logic                     buf_valid,
    output logic                     frozen
);

    localparam int unsigned P_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W = P_W + 1;

    buf_state_t          r_state;
    buf_state_t          w_state_nxt;
    ang_t                r_buf [0:DEPTH-1];
    logic [P_W-1:0]      r_ptr;
    logic [P_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_buf_valid;
    logic                r_frozen;
    logic                w_write;

    // Input acceptance depends only on freeze; no path from in_valid.
    assign in_ready = !freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pointer and fill count; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_write     = in_valid && !freeze && !flush;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_ptr_nxt   = '1;
            w_cnt_nxt   = '0;
        end else begin
            if (w_write) begin
                w_ptr_nxt = r_ptr + P_W'(1);
                if (r_cnt != CNT_W'(DEPTH)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                EMPTY:   if (w_write) w_state_nxt = FILL;
                FILL:    if (w_write && (r_cnt == CNT_W'(DEPTH - 1))) w_state_nxt = FULL;
                FULL:    if (freeze) w_state_nxt = FROZEN;
                FROZEN:  if (!freeze) w_state_nxt = FULL;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '1;
            r_cnt       <= '0;
            r_buf_valid <= 1'b0;
            r_frozen    <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_buf_valid <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_frozen    <= (w_state_nxt == FROZEN);
        end
    end

    // Storage is flops so the reader gets random combinational access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_write) begin
            r_buf[w_ptr_nxt] <= angle_in;
        end
    end

    assign angle_buf = r_buf;
    assign write_ptr = r_ptr;
    assign buf_valid = r_buf_valid;
    assign frozen    = r_frozen;

endmodule

// File: tb/tb_angle_buf_writer.sv
// Directed bench for angle_buf_writer followed by a randomized scoreboard phase.
module tb_angle_buf_writer;
    import angle_buf_writer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    ang_t       angle_in;
    logic       freeze;
    logic       flush;
    ang_t       angle_buf [0:255];
    logic [7:0] write_ptr;
    logic       buf_valid;
    logic       frozen;

    int checks = 0;
    int errors = 0;

    ang_t       m_buf [0:255];
    logic [7:0] m_ptr;
    int         m_cnt;
    logic       m_frz;
    logic [7:0] ridx;
    int         acc;
    int         cyc;

    angle_buf_writer #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .freeze    (freeze),
        .flush     (flush),
        .angle_buf (angle_buf),
        .write_ptr (write_ptr),
        .buf_valid (buf_valid),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        in_valid = 1'b1;
        angle_in = ang_t'(v);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int first_bad();
        for (int k = 0; k < 256; k++) begin
            if (angle_buf[k] !== m_buf[k]) return k;
        end
        return -1;
    endfunction

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        angle_in = '0;
        freeze   = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_ptr",      32'(write_ptr),    32'hFF);
        chk("rst_valid",    32'(buf_valid),    0);
        chk("rst_frozen",   32'(frozen),       0);
        chk("rst_ready",    32'(in_ready),     1);
        chk("rst_buf0",     32'(angle_buf[0]), 0);
        chk("rst_buf255",   32'(angle_buf[255]), 0);
        tick();
        rst_n = 1'b1;

        // First fill: angle_in = i
        for (int i = 0; i < 256; i++) begin
            wr(i);
            if (i == 0) chk("first_ptr", 32'(write_ptr), 0);
            if (i == 254) begin
                chk("fill255_valid", 32'(buf_valid), 0);
                chk("fill255_ptr",   32'(write_ptr), 254);
            end
        end
        chk("fill256_ptr",   32'(write_ptr), 32'hFF);
        chk("fill256_valid", 32'(buf_valid), 1);
        for (int k = 0; k < 256; k++) chk("fill_data", 32'(angle_buf[k]), k);

        // Overwrite oldest entries
        wr(1000); wr(1001); wr(1002);
        chk("ow_buf0",  32'(angle_buf[0]), 1000);
        chk("ow_buf1",  32'(angle_buf[1]), 1001);
        chk("ow_buf2",  32'(angle_buf[2]), 1002);
        chk("ow_ptr",   32'(write_ptr),    2);
        chk("ow_valid", 32'(buf_valid),    1);
        ridx = write_ptr - 8'd255;
        chk("ow_oldest_idx", 32'(ridx),            3);
        chk("ow_oldest_val", 32'(angle_buf[ridx]), 3);

        // Freeze in FULL with a pending sample
        in_valid = 1'b1;
        angle_in = ang_t'(-5);
        freeze   = 1'b1;
        #1 chk("frz_ready", 32'(in_ready), 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("frz_frozen", 32'(frozen),       1);
            chk("frz_ptr",    32'(write_ptr),    2);
            chk("frz_buf3",   32'(angle_buf[3]), 3);
            chk("frz_valid",  32'(buf_valid),    1);
        end
        freeze = 1'b0;
        #1 chk("unfrz_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("unfrz_ptr",    32'(write_ptr),    3);
        chk("unfrz_buf3",   32'(angle_buf[3]), -5);
        chk("unfrz_frozen", 32'(frozen),       0);

        // Flush from FULL, refill to 100, then flush with a concurrent sample
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl1_ptr",   32'(write_ptr), 32'hFF);
        chk("fl1_valid", 32'(buf_valid), 0);
        for (int i = 0; i < 100; i++) wr(2000 + i);
        chk("fl_cnt100_ptr", 32'(write_ptr), 99);
        flush    = 1'b1;
        in_valid = 1'b1;
        angle_in = ang_t'(777);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2_ptr",    32'(write_ptr),      32'hFF);
        chk("fl2_valid",  32'(buf_valid),      0);
        chk("fl2_drop",   32'(angle_buf[100]), 100);
        chk("fl2_keep0",  32'(angle_buf[0]),   2000);
        for (int i = 0; i < 255; i++) wr(3000 + i);
        chk("refill255_valid", 32'(buf_valid), 0);
        chk("refill255_ptr",   32'(write_ptr), 254);
        wr(3255);
        chk("refill256_valid", 32'(buf_valid), 1);
        chk("refill256_ptr",   32'(write_ptr), 32'hFF);

        // Flush beats freeze
        freeze = 1'b1;
        tick();
        chk("ff_frozen", 32'(frozen), 1);
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        freeze = 1'b0;
        chk("ff_frozen_clr", 32'(frozen),    0);
        chk("ff_valid",      32'(buf_valid), 0);
        chk("ff_ptr",        32'(write_ptr), 32'hFF);

        // Asynchronous reset mid-fill at count 200
        for (int i = 0; i < 200; i++) wr(i + 1);
        chk("cnt200_ptr", 32'(write_ptr), 199);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ptr",   32'(write_ptr),    32'hFF);
        chk("arst_valid", 32'(buf_valid),    0);
        chk("arst_buf5",  32'(angle_buf[5]), 0);
        #1 rst_n = 1'b1;
        wr(42);
        chk("arst_wr_ptr",   32'(write_ptr),    0);
        chk("arst_wr_buf0",  32'(angle_buf[0]), 42);
        chk("arst_wr_valid", 32'(buf_valid),    0);

        // Freeze while filling stalls input but does not enter FROZEN
        freeze   = 1'b1;
        in_valid = 1'b1;
        angle_in = ang_t'(9);
        #1 chk("fillfrz_ready", 32'(in_ready), 0);
        tick();
        tick();
        chk("fillfrz_ptr",    32'(write_ptr),    0);
        chk("fillfrz_frozen", 32'(frozen),       0);
        chk("fillfrz_buf1",   32'(angle_buf[1]), 0);
        freeze   = 1'b0;
        in_valid = 1'b0;

        // Randomized gaps against a scoreboard, from a fresh reset
        tick();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 256; k++) m_buf[k] = '0;
        m_ptr = 8'hFF;
        m_cnt = 0;
        acc   = 0;
        cyc   = 0;
        while (acc < 1000 && cyc < 8000) begin
            in_valid = ($urandom_range(0, 9) < 7);
            angle_in = ang_t'($urandom_range(0, 8191));
            if (freeze) begin
                if ($urandom_range(0, 3) == 0) freeze = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) freeze = 1'b1;
            end
            #1 chk("rnd_ready", 32'(in_ready), 32'(!freeze));
            m_frz = (m_cnt == 256) && freeze;
            if (in_valid && !freeze) begin
                m_ptr = m_ptr + 8'd1;
                m_buf[m_ptr] = angle_in;
                if (m_cnt < 256) m_cnt++;
                acc++;
            end
            tick();
            chk("rnd_ptr",    32'(write_ptr), 32'(m_ptr));
            chk("rnd_valid",  32'(buf_valid), 32'(m_cnt == 256));
            chk("rnd_frozen", 32'(frozen),    32'(m_frz));
            chk("rnd_array",  first_bad(),    -1);
            cyc++;
        end
        in_valid = 1'b0;
        freeze   = 1'b0;
        chk("rnd_done", acc, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/angle_buf_writer.md
Name: angle_buf_writer

Overview:
- Writer side of the 256-entry circular angle history used by the eps selector.
- Accepts one phase-angle sample per valid/ready handshake and stores it in a circular register array.
- Publishes the array, the index of the newest entry and a fill indication (buf_valid).
- Can freeze the buffer so a downstream reader sees stable contents while computing eps.

Parameters:
- DEPTH, 256, number of entries; must be a power of two, and ptr width = log2(DEPTH) = 8.
- ANG_W, 13, width of ang_t (signed); informational only, the type comes from the shared package.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  writer can accept; equals !freeze.
- angle_in  in  ang_t  signed phase sample.
- freeze  in  1  hold buffer, pointer and state; stalls input.
- flush  in  1  synchronous restart of filling.
- angle_buf  out  ang_t [0:DEPTH-1]  registered storage.
- write_ptr  out  8  index of the most recently written entry.
- buf_valid  out  1  DEPTH samples written since reset/flush.
- frozen  out  1  high while in FROZEN state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - angle_buf all zero, write_ptr=8'hFF, fill count=0, state=EMPTY.
  - buf_valid=0, frozen=0.
- Write:
  - A write occurs on a rising clk edge when in_valid && in_ready && !flush.
  - On a write, write_ptr <= write_ptr+1 (mod 256) and angle_buf[new ptr] <= angle_in.
  - The first sample after reset therefore lands at index 0, with write_ptr=0.
  - Latency is 1 cycle: angle_buf and write_ptr reflect the sample on the cycle after the handshake.
- Pointer convention: oldest entry = write_ptr+1, newest = write_ptr. A reader computes index write_ptr-(255-theta) = oldest+theta.
- Fill count:
  - 9-bit, increments on each write and saturates at DEPTH.
  - buf_valid is registered and equals (count==DEPTH); it rises in the same cycle write_ptr becomes 8'hFF after the 256th write.
- States:
  - EMPTY: count==0. First write -> FILL.
  - FILL: 0<count<DEPTH. The write that makes count=DEPTH -> FULL.
  - FULL: writes continue and overwrite the oldest entry; buf_valid stays 1. freeze=1 -> FROZEN.
  - FROZEN: no writes; angle_buf, write_ptr and buf_valid are held; frozen=1. freeze=0 -> FULL.
  - freeze during EMPTY/FILL: stalls input (in_ready=0) but the state is unchanged and frozen stays 0.
- Flush:
  - Any state -> EMPTY next cycle: count=0, buf_valid=0, write_ptr=8'hFF.
  - angle_buf contents are not cleared.
  - flush has priority over a concurrent handshake (the sample is dropped) and over freeze.
- Other boundaries:
  - write_ptr wraps 8'hFF -> 8'h00 silently.
  - in_valid while in_ready=0: no state change; the source must hold the sample.
  - rst_n deasserting mid-fill restarts from EMPTY; no partial buf_valid.
- in_ready is combinational from freeze only; there is no combinational path from in_valid.

Decomposition:
- Shared data_type package/header holds:
  - ang_t, theta_t, eps_t;
  - BUF_DEPTH=256 and the pointer typedef;
  - a buf_state_t enum {EMPTY, FILL, FULL, FROZEN}.
- The INV_TWO_PI constant moves to the package, so the writer and selector share one definition.
- The block is monolithic; no sub-module is warranted. The storage array is registers, not an SRAM macro, because the reader needs random combinational access.

Test Plan:
- Reset, then 256 writes with angle_in=i (i=0..255) -> after the last write write_ptr=8'hFF, buf_valid=1, angle_buf[k]=k; buf_valid stays 0 after write 255.
- Continue with 3 writes of 1000,1001,1002 -> angle_buf[0..2]=1000..1002, write_ptr=2, and reader index write_ptr-(255-0)=3 reads value 3 (oldest).
- In FULL, freeze=1 for 10 cycles with in_valid=1 -> in_ready=0, frozen=1, write_ptr/array unchanged; on freeze=0 the held sample is written on the next edge.
- flush and in_valid in the same cycle with count=100 -> next cycle count=0, write_ptr=8'hFF, buf_valid=0, sample not written.
- rst_n pulsed low asynchronously mid-cycle at count=200 -> outputs zero/8'hFF immediately, state EMPTY, and the next write goes to index 0.
- Random in_valid/freeze gaps over 1000 samples -> scoreboard model of the array/pointer matches every cycle, and buf_valid equals (writes since reset>=256).
